sound_player: RTL and testbench

//  Back end of the bouncing-numbers sound interface. Latches a 2-bit sound code
//  (stop/ping/pong/go) on a one-cycle play strobe and renders it as a square-wave

---
 rtl/sound_player_if.sv | 22 ++
 rtl/sound_player.sv | 136 +++++++++++++
 tb/tb_sound_player.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sound_player_if.sv
// Sound interface between the animation block and the buzzer back end.
// Latency: n/a (wires only).
// Backpressure: none; play is a fire-and-forget strobe, outputs are levels/pulses.
//
// Signals:
//   play        strobe from animation block: sample code_sound this cycle
//   code_sound  00 stop, 10 ping, 01 pong, 11 go
//   mute        level: silence the buzzer without disturbing timing
//   buzzer      square-wave speaker drive
//   busy        high while a tone or inter-note gap is in progress
//   done        one-cycle pulse when a sequence completes naturally
interface sound_player_if;
    logic       play;
    logic [1:0] code_sound;
    logic       mute;
    logic       buzzer;
    logic       busy;
    logic       done;

    modport master (output play, code_sound, mute, input buzzer, busy, done);
    modport slave  (input play, code_sound, mute, output buzzer, busy, done);
endinterface

// File: rtl/sound_player.sv
// Renders a latched sound code (stop/ping/pong/go) as a square-wave tone burst.
// Latency: state/busy follow the play strobe by one clock; buzzer lags phase by one clock.
// Backpressure: none; a new play always restarts (or stops) whatever is in progress.
//
// Ports: clk (system clock), clr (async active-low reset),
//        bus (sound_player_if.slave: play, code_sound, mute in; buzzer, busy, done out)
module sound_player #(
    parameter int PING_HALF = 25000,
    parameter int PONG_HALF = 50000,
    parameter int TONE_LEN  = 5000000,
    parameter int GAP_LEN   = 1250000,
    parameter int HW        = 17,
    parameter int LW        = 24
) (
    input  logic           clk,
    input  logic           clr,
    sound_player_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    localparam logic [HW-1:0] PING_H   = HW'(PING_HALF);
    localparam logic [HW-1:0] PONG_H   = HW'(PONG_HALF);
    localparam logic [LW-1:0] TONE_END = LW'(TONE_LEN - 1);
    localparam logic [LW-1:0] GAP_END  = LW'(GAP_LEN - 1);

    localparam logic [1:0] CODE_STOP = 2'b00;
    localparam logic [1:0] CODE_PING = 2'b10;
    localparam logic [1:0] CODE_PONG = 2'b01;

    state_t        state, state_n;
    logic [1:0]    note, note_n;       // position within the go sequence
    logic          go, go_n;           // current burst is the three-note sequence
    logic [HW-1:0] half, half_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [LW-1:0] dcnt, dcnt_n;
    logic          phase, phase_n;
    logic          buzzer_n, busy_n, done_n;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            note       <= 2'd0;
            go         <= 1'b0;
            half       <= '0;
            hcnt       <= '0;
            dcnt       <= '0;
            phase      <= 1'b0;
            bus.buzzer <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            state      <= state_n;
            note       <= note_n;
            go         <= go_n;
            half       <= half_n;
            hcnt       <= hcnt_n;
            dcnt       <= dcnt_n;
            phase      <= phase_n;
            bus.buzzer <= buzzer_n;
            bus.busy   <= busy_n;
            bus.done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        note_n  = note;
        go_n    = go;
        half_n  = half;
        hcnt_n  = hcnt;
        dcnt_n  = dcnt;
        phase_n = phase;
        done_n  = 1'b0;

        if (bus.play) begin
            // Any strobe aborts the current burst without a done pulse.
            note_n  = 2'd0;
            hcnt_n  = '0;
            dcnt_n  = '0;
            phase_n = 1'b0;
            go_n    = 1'b0;
            case (bus.code_sound)
                CODE_STOP: state_n = IDLE;
                CODE_PING: begin state_n = TONE; half_n = PING_H; end
                CODE_PONG: begin state_n = TONE; half_n = PONG_H; end
                default:   begin state_n = TONE; half_n = PING_H; go_n = 1'b1; end
            endcase
        end else begin
            case (state)
                TONE: begin
                    if (dcnt == TONE_END) begin
                        dcnt_n  = '0;
                        hcnt_n  = '0;
                        phase_n = 1'b0;
                        if (go && note != 2'd2) begin
                            state_n = GAP;
                            note_n  = note + 2'd1;
                        end else begin
                            state_n = IDLE;
                            go_n    = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                        if (hcnt == half - 1'b1) begin
                            hcnt_n  = '0;
                            phase_n = ~phase;
                        end else begin
                            hcnt_n = hcnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (dcnt == GAP_END) begin
                        dcnt_n  = '0;
                        hcnt_n  = '0;
                        phase_n = 1'b0;
                        state_n = TONE;
                        // Go sequence is ping, pong, ping: only the middle note is pong.
                        half_n  = (note == 2'd1) ? PONG_H : PING_H;
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Uses the current phase (one-cycle lag) but the next state, so the pin
        // drops in the same cycle the tone ends rather than one cycle later.
        buzzer_n = phase & ~bus.mute & (state_n == TONE);
        busy_n   = (state_n != IDLE);
    end

endmodule

// File: tb/tb_sound_player.sv
module tb_sound_player;

    localparam int PH = 4;
    localparam int QH = 8;
    localparam int TL = 40;
    localparam int GL = 10;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    sound_player_if bus();

    sound_player #(
        .PING_HALF(PH), .PONG_HALF(QH), .TONE_LEN(TL), .GAP_LEN(GL), .HW(17), .LW(24)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct packed {
        logic buz;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model state: which burst is active and when it started.
    bit   active     = 0;
    int   start      = 0;
    int   seq        = 0;
    bit   prev_phase = 0;
    exp_t last_exp   = '0;

    function automatic int note_half(int s, int k);
        if (s == 1) return QH;          // pong
        if (s == 3 && k == 1) return QH; // middle note of go
        return PH;
    endfunction

    task automatic check(string name, logic got, logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, got, want);
        end
    endtask

    // Model: at each rising edge, derive what the outputs must be for the cycle
    // that edge begins, straight from the burst timeline.
    initial begin
        forever begin
            exp_t e;
            bit   tone;
            bit   ph;
            @(posedge clk);
            cyc++;
            e = '0;
            tone = 0;
            ph = 0;
            if (!clr) begin
                active = 0;
                prev_phase = 0;
            end else begin
                if (bus.play) begin
                    if (bus.code_sound == 2'b00) begin
                        active = 0;
                    end else begin
                        active = 1;
                        start  = cyc;
                        seq    = int'(bus.code_sound);
                    end
                end
                if (active) begin
                    int o, nn, endo;
                    o    = cyc - start;
                    nn   = (seq == 3) ? 3 : 1;
                    endo = (nn - 1) * (TL + GL) + TL;
                    if (o == endo) begin
                        e.done = 1'b1;
                        active = 0;
                    end else begin
                        for (int k = 0; k < nn; k++) begin
                            int b, h;
                            b = k * (TL + GL);
                            if (o >= b && o < b + TL) begin
                                h    = note_half(seq, k);
                                tone = 1;
                                ph   = (((o - b) / h) % 2) == 1;
                            end
                        end
                    end
                end
                e.busy = active;
                e.buz  = tone && prev_phase && !bus.mute;
                prev_phase = ph;
            end
            last_exp = e;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("buzzer", bus.buzzer, e.buz);
                check("busy",   bus.busy,   e.busy);
                check("done",   bus.done,   e.done);
            end
        end
    end

    // One cycle of stimulus, presented on the falling edge.
    task automatic drive(input logic p, input logic [1:0] c, input logic m);
        bus.play       = p;
        bus.code_sound = c;
        bus.mute       = m;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom_range(0, 3)), m);
    endtask

    initial begin
        bus.play = 1'b0;
        bus.code_sound = 2'b00;
        bus.mute = 1'b0;

        #2;
        check("rst_buzzer", bus.buzzer, 1'b0);
        check("rst_busy",   bus.busy,   1'b0);
        check("rst_done",   bus.done,   1'b0);
        repeat (3) @(negedge clk);
        #1 clr = 1'b1;

        // 1: single ping
        drive(1'b1, 2'b10, 1'b0);
        idle(49, 1'b0);
        // 2: go sequence
        drive(1'b1, 2'b11, 1'b0);
        idle(150, 1'b0);
        // 3: pong with mute window in cycles 10..20
        drive(1'b1, 2'b01, 1'b0);
        idle(9, 1'b0);
        idle(11, 1'b1);
        idle(30, 1'b0);
        // 4: go, stop at cycle 60
        drive(1'b1, 2'b11, 1'b0);
        idle(59, 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        idle(100, 1'b0);
        // 5: ping, preempted by pong at cycle 15
        drive(1'b1, 2'b10, 1'b0);
        idle(14, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        idle(50, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic p;
            p = ($urandom_range(0, 39) == 0);
            drive(p, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        idle(160, 1'b0);

        // 6: asynchronous clear while the buzzer is high
        drive(1'b1, 2'b10, 1'b0);
        begin
            int guard = 0;
            while (!last_exp.buz && guard < 20) begin
                idle(1, 1'b0);
                guard++;
            end
            n_tests++;
            if (!last_exp.buz) begin
                n_fail++;
                $display("FAIL clr_setup cyc=%0d got=0 want=1 (buzzer never expected high)", cyc);
            end
        end
        #1 clr = 1'b0;
        #1;
        check("clr_buzzer", bus.buzzer, 1'b0);
        check("clr_busy",   bus.busy,   1'b0);
        check("clr_done",   bus.done,   1'b0);
        idle(3, 1'b0);
        #1 clr = 1'b1;
        idle(20, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        idle(50, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
